bcd_score_accum: RTL and testbench

BCD_SCORE_ACCUM -- requirements
Module: bcd_score_accum

---
 rtl/bcd_score_accum.sv | 152 +++++++++++++++
 tb/tb_bcd_score_accum.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_accum.sv
// Serial BCD score accumulator: adds or subtracts a packed BCD operand to/from the
// running score one digit per clock, LSD first, with optional clamp on overflow/underflow.
module bcd_score_accum #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic                  clear,
    input  logic [DIGITS*4-1:0]   operand,
    output logic [DIGITS*4-1:0]   score,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int W = DIGITS * 4;
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] score_q;
    logic [W-1:0] work_q;
    logic [W-1:0] opnd_q;
    logic [3:0]   idx_q;
    logic         op_q;
    logic         cy_q;
    logic         busy_q;
    logic         done_q;
    logic         ovf_q;

    logic [W-1:0] opnd_clean_d;
    logic [W-1:0] nines_d;
    logic [4:0]   sum_d;
    logic [4:0]   dif_d;
    logic [4:0]   sum_adj_d;
    logic [4:0]   dif_adj_d;
    logic [3:0]   res_d;
    logic         cy_d;

    // Out-of-range operand digits clamp to 9 so the working value stays valid BCD.
    always_comb begin
        opnd_clean_d = '0;
        nines_d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            opnd_clean_d[i*4 +: 4] = (operand[i*4 +: 4] > 4'd9) ? 4'd9 : operand[i*4 +: 4];
            nines_d[i*4 +: 4]      = 4'd9;
        end
    end

    // Working and operand registers rotate right each RUN cycle, so digit 0 is always current.
    always_comb begin
        sum_d     = {1'b0, work_q[3:0]} + {1'b0, opnd_q[3:0]} + {4'd0, cy_q};
        dif_d     = {1'b0, work_q[3:0]} - {1'b0, opnd_q[3:0]} - {4'd0, cy_q};
        sum_adj_d = sum_d - 5'd10;
        dif_adj_d = dif_d + 5'd10;
        res_d     = sum_d[3:0];
        cy_d      = 1'b0;
        if (!op_q) begin
            if (sum_d >= 5'd10) begin
                res_d = sum_adj_d[3:0];
                cy_d  = 1'b1;
            end
        end else begin
            res_d = dif_d[3:0];
            if (dif_d[4]) begin
                res_d = dif_adj_d[3:0];
                cy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            score_q <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            score_q <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    // busy_q is still high in the done cycle, which blocks a start there.
                    if (start && !busy_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        work_q  <= score_q;
                        opnd_q  <= opnd_clean_d;
                        op_q    <= op;
                        cy_q    <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    work_q <= {res_d, work_q[W-1:4]};
                    opnd_q <= {4'd0, opnd_q[W-1:4]};
                    cy_q   <= cy_d;
                    idx_q  <= idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    ovf_q   <= cy_q;
                    if (cy_q && SATURATE) begin
                        score_q <= op_q ? '0 : nines_d;
                    end else begin
                        score_q <= work_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign score = score_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_score_accum.sv
// Bench for bcd_score_accum: a saturating and a wrapping instance share one stimulus
// stream; each has its own expected queue drained by a done-driven monitor.
module tb_bcd_score_accum;

    typedef struct packed {
        logic [15:0] score;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] operand = '0;

    logic [15:0] score_s, score_w;
    logic        busy_s, busy_w, done_s, done_w, ovf_s, ovf_w;

    logic [31:0] cyc = '0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q_sat[$];
    exp_t        q_wrap[$];
    logic [15:0] m_sat = '0;
    logic [15:0] m_wrap = '0;

    bcd_score_accum #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .op(op), .clear(clear),
        .operand(operand), .score(score_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
    );

    bcd_score_accum #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .op(op), .clear(clear),
        .operand(operand), .score(score_w), .busy(busy_w), .done(done_w), .ovf(ovf_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done_s === 1'b1) begin
            if (q_sat.size() == 0) begin
                chk("sat_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_sat.pop_front();
                chk("sat_score", {16'd0, score_s}, {16'd0, e.score});
                chk("sat_ovf", {31'd0, ovf_s}, {31'd0, e.ovf});
                chk("sat_done_cycle", cyc, e.cyc);
            end
        end
        if (done_w === 1'b1) begin
            if (q_wrap.size() == 0) begin
                chk("wrap_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_wrap.pop_front();
                chk("wrap_score", {16'd0, score_w}, {16'd0, e.score});
                chk("wrap_ovf", {31'd0, ovf_w}, {31'd0, e.ovf});
                chk("wrap_done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one operation; optionally pulse start while busy and in the done cycle.
    task automatic do_op(input logic op_v, input logic [15:0] opnd, input logic spurious,
                         input logic [15:0] es, input logic eos,
                         input logic [15:0] ew, input logic eow);
        exp_t e;
        start   = 1'b1;
        op      = op_v;
        operand = opnd;
        e.cyc   = cyc + 32'd6;
        e.score = es;
        e.ovf   = eos;
        q_sat.push_back(e);
        e.score = ew;
        e.ovf   = eow;
        q_wrap.push_back(e);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = spurious && (k == 2 || k == 6);
            if (k == 3) begin
                chk("sat_hold_in_run", {16'd0, score_s}, {16'd0, m_sat});
                chk("wrap_hold_in_run", {16'd0, score_w}, {16'd0, m_wrap});
                chk("sat_busy_in_run", {31'd0, busy_s}, 32'd1);
            end
        end
        chk("sat_drained", q_sat.size(), 32'd0);
        chk("wrap_drained", q_wrap.size(), 32'd0);
        chk("sat_busy_after", {31'd0, busy_s}, 32'd0);
        m_sat  = es;
        m_wrap = ew;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("sat_clear_score", {16'd0, score_s}, 32'd0);
        chk("wrap_clear_score", {16'd0, score_w}, 32'd0);
        chk("sat_clear_ovf", {31'd0, ovf_s}, 32'd0);
        chk("wrap_clear_ovf", {31'd0, ovf_w}, 32'd0);
        m_sat  = '0;
        m_wrap = '0;
    endtask

    // Start an add, then abort it in the second RUN cycle with clear or rst.
    task automatic do_abort(input logic use_rst);
        start   = 1'b1;
        op      = 1'b0;
        operand = 16'h0200;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                if (use_rst) rst = 1'b1;
                else clear = 1'b1;
            end
            if (k == 3) begin
                rst   = 1'b0;
                clear = 1'b0;
                chk("abort_sat_score", {16'd0, score_s}, 32'd0);
                chk("abort_wrap_score", {16'd0, score_w}, 32'd0);
                chk("abort_sat_busy", {31'd0, busy_s}, 32'd0);
                chk("abort_sat_done", {31'd0, done_s}, 32'd0);
                chk("abort_sat_ovf", {31'd0, ovf_s}, 32'd0);
                chk("abort_wrap_busy", {31'd0, busy_w}, 32'd0);
            end
        end
        m_sat  = '0;
        m_wrap = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_score", {16'd0, score_s}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_done", {31'd0, done_s}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);
        do_clear();
        do_op(1'b0, 16'h0999, 1'b0, 16'h0999, 1'b0, 16'h0999, 1'b0);
        do_op(1'b0, 16'h0001, 1'b0, 16'h1000, 1'b0, 16'h1000, 1'b0);
        do_clear();
        do_op(1'b0, 16'h9990, 1'b0, 16'h9990, 1'b0, 16'h9990, 1'b0);
        do_op(1'b0, 16'h0020, 1'b0, 16'h9999, 1'b1, 16'h0010, 1'b1);
        do_clear();
        do_op(1'b0, 16'h0003, 1'b0, 16'h0003, 1'b0, 16'h0003, 1'b0);
        do_op(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h9998, 1'b1);
        do_op(1'b0, 16'h0007, 1'b0, 16'h0007, 1'b0, 16'h0005, 1'b1);
        do_clear();

        // clear and start together: clear wins, no operation starts
        clear   = 1'b1;
        start   = 1'b1;
        operand = 16'h0500;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        chk("clr_start_busy", {31'd0, busy_s}, 32'd0);
        chk("clr_start_score", {16'd0, score_s}, 32'd0);
        repeat (7) @(negedge clk);

        do_op(1'b0, 16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b0);
        do_abort(1'b0);
        do_op(1'b0, 16'h1F2F, 1'b0, 16'h1929, 1'b0, 16'h1929, 1'b0);
        do_op(1'b1, 16'h0930, 1'b0, 16'h0999, 1'b0, 16'h0999, 1'b0);
        do_abort(1'b1);

        repeat (10) @(negedge clk);
        chk("final_sat_queue", q_sat.size(), 32'd0);
        chk("final_wrap_queue", q_wrap.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
